// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for a shared tristate bus; adds TURN_CYC idle cycles between grants and caps tenure at MAX_HOLD when contended.
// Latency: grant is registered 1 edge after req from idle; no backpressure, devices hold req as a level.
module bus_arbiter_rr #(
  parameter  int NREQ     = 4,
  parameter  int TURN_CYC = 1,
  parameter  int MAX_HOLD = 8,
  localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int HW       = $clog2(MAX_HOLD + 1),
  localparam int TW       = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [OW-1:0]   owner,
  output logic            bus_busy,
  output logic            preempt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   last, last_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [TW-1:0]   turn_cnt, turn_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [OW-1:0]   owner_nxt;
  logic            busy_nxt;
  logic            preempt_nxt;

  logic            win_vld;
  logic [OW-1:0]   win_idx;
  logic [OW-1:0]   cand;
  logic [NREQ-1:0] win_onehot;
  logic            own_req;
  logic            other_req;
  logic            hold_sat;
  logic            take;
  logic            rel;

  // Search starts one past the last winner so the previous owner is considered last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = OW'((int'(last) + 1 + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  // grant is one-hot on the owner while in GRANT, so it doubles as the owner mask.
  assign own_req    = |(req & grant);
  assign other_req  = |(req & ~grant);
  assign hold_sat   = (hold_cnt >= HW'(MAX_HOLD));

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    owner_nxt   = owner;
    last_nxt    = last;
    hold_nxt    = hold_cnt;
    turn_nxt    = turn_cnt;
    busy_nxt    = bus_busy;
    preempt_nxt = 1'b0;
    take        = 1'b0;
    rel         = 1'b0;

    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (win_vld) begin
          take = 1'b1;
        end
      end
      S_GRANT: begin
        if (!own_req) begin
          rel = 1'b1;
        end else if (hold_sat && other_req) begin
          rel         = 1'b1;
          preempt_nxt = 1'b1;
        end else if (!hold_sat) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      S_TURN: begin
        if (turn_cnt != '0) begin
          turn_nxt = turn_cnt - TW'(1);
        end else if (win_vld) begin
          take = 1'b1;
        end else begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase

    if (take) begin
      state_nxt = S_GRANT;
      grant_nxt = win_onehot;
      owner_nxt = win_idx;
      last_nxt  = win_idx;
      hold_nxt  = HW'(1);
      busy_nxt  = 1'b1;
    end

    if (rel) begin
      state_nxt = S_TURN;
      grant_nxt = '0;
      turn_nxt  = TW'(TURN_CYC - 1);
      busy_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      owner    <= '0;
      last     <= OW'(NREQ - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
      bus_busy <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
      bus_busy <= busy_nxt;
      preempt  <= preempt_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench: a tenure/gap reference model predicts each cycle's outputs; a monitor pops and compares.
module tb_bus_arbiter_rr;

  localparam int NREQ     = 4;
  localparam int TURN_CYC = 1;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       bus_busy;
  logic       preempt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    logic       p;
  } exp_t;

  exp_t sb[$];

  // Reference model state: current owner (-1 = none), cycles granted so far,
  // idle gap cycles still to run, last winner, reported owner, preempt flag.
  int m_cur    = -1;
  int m_tenure = 0;
  int m_gap    = 0;
  int m_last   = NREQ - 1;
  int m_owner  = 0;
  int m_pre    = 0;

  bus_arbiter_rr #(
    .NREQ(NREQ),
    .TURN_CYC(TURN_CYC),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .grant(grant),
    .owner(owner),
    .bus_busy(bus_busy),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  function automatic logic bit_of(input logic [3:0] v, input int i);
    return |(v & (4'b0001 << i));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, want);
    end
  endtask

  // Advances the model by one clock edge that samples (r, q).
  task automatic model_step(input logic r, input logic [3:0] q);
    bit can_grant;
    bit others;
    bit found;
    int i;
    if (r) begin
      m_cur   = -1;
      m_gap   = 0;
      m_last  = NREQ - 1;
      m_owner = 0;
      m_pre   = 0;
      return;
    end
    can_grant = 0;
    m_pre     = 0;
    if (m_cur >= 0) begin
      others = 0;
      for (int j = 0; j < NREQ; j++)
        if (j != m_cur && bit_of(q, j)) others = 1;
      if (!bit_of(q, m_cur)) begin
        m_cur = -1;
        m_gap = TURN_CYC;
      end else if (m_tenure >= MAX_HOLD && others) begin
        m_cur = -1;
        m_gap = TURN_CYC;
        m_pre = 1;
      end else begin
        m_tenure++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      can_grant = (m_gap == 0);
    end else begin
      can_grant = 1;
    end
    if (can_grant) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_last + k) % NREQ;
        if (!found && bit_of(q, i)) begin
          found    = 1;
          m_cur    = i;
          m_last   = i;
          m_owner  = i;
          m_tenure = 1;
        end
      end
    end
  endtask

  // Drives one cycle of inputs and queues the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic [3:0] q);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = q;
    model_step(r, q);
    e.g = (m_cur >= 0) ? (4'b0001 << m_cur) : 4'b0000;
    e.o = 2'(m_owner);
    e.b = (m_cur >= 0) || (m_gap > 0);
    e.p = (m_pre != 0);
    sb.push_back(e);
  endtask

  task automatic run(input logic r, input logic [3:0] q, input int n);
    for (int k = 0; k < n; k++) cyc(r, q);
  endtask

  // Monitor: every cycle the DUT presents a full output set, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("grant",    32'(grant),    32'(e.g));
        chk("owner",    32'(owner),    32'(e.o));
        chk("bus_busy", 32'(bus_busy), 32'(e.b));
        chk("preempt",  32'(preempt),  32'(e.p));
        chk("onehot0",  32'($onehot0(grant)), 32'd1);
      end
    end
  end

  initial begin
    logic [3:0] q;
    logic       r;

    // Reset with all requests up, then release.
    run(1'b1, 4'b1111, 2);
    run(1'b0, 4'b1111, 3);
    run(1'b0, 4'b0000, 3);

    // Single tenure.
    run(1'b0, 4'b0010, 3);
    run(1'b0, 4'b0000, 3);

    // Round-robin with preemption, starting from a fresh reset.
    run(1'b1, 4'b0000, 1);
    run(1'b0, 4'b0101, 16);
    run(1'b0, 4'b0000, 3);

    // Lone saturation, then a late competitor.
    run(1'b0, 4'b1000, 11);
    run(1'b0, 4'b1001, 4);
    run(1'b0, 4'b0000, 3);

    // Handover on drop.
    run(1'b0, 4'b0001, 3);
    run(1'b0, 4'b0100, 3);
    run(1'b0, 4'b0000, 3);

    // Reset mid-grant.
    run(1'b0, 4'b0100, 2);
    run(1'b1, 4'b0100, 1);
    run(1'b0, 4'b0101, 4);
    run(1'b0, 4'b0000, 3);

    // Randomized traffic with occasional resets.
    q = 4'b0000;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 5) == 0) q = q ^ (4'b0001 << b);
      r = ($urandom_range(0, 99) == 0);
      cyc(r, q);
    end
    run(1'b0, 4'b0000, 4);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
